// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// the default header tag and the header byte constructor.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEADER,
        ARB_STREAM
    } arb_state_t;

    localparam logic [3:0] UART_HDR_TAG_DEFAULT = 4'hA;

    // Header byte layout seen by the host: tag in the upper nibble, requester id below.
    function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [3:0] id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping cyclically, using a doubled request vector.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   window;
    logic [IW:0]    sum;

    // Bit k of the window is request (ptr_i + k) mod N, so the lowest set bit wins.
    assign doubled = {req_i, req_i};
    assign window  = doubled[ptr_i +: N];

    always_comb begin
        found_o = 1'b0;
        sum     = '0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (window[i]) begin
                found_o = 1'b1;
                sum     = {1'b0, ptr_i} + (IW + 1)'(i);
            end
        end
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmit FIFO among
// NUM_REQ byte streams; each packet is prefixed with a {tag, id} header byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter logic [3:0] HDR_TAG = UART_HDR_TAG_DEFAULT,
    localparam int        ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           uart_data_o,
    output logic                 uart_wr_en_o,
    input  logic                 uart_fifo_full_i,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_o
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    logic [7:0]      req_byte [NUM_REQ];
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            xfer;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Only the granted requester sees ready, and only while the FIFO has room.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]    = req_data_i[8*gi +: 8];
            assign req_ready_o[gi] = (state_q == ARB_STREAM) && (grant_q == ID_W'(gi))
                                     && !uart_fifo_full_i;
        end
    endgenerate

    assign sel_valid = req_valid_i[grant_q];
    assign sel_last  = req_last_i[grant_q];
    assign sel_data  = req_byte[grant_q];
    assign xfer      = (state_q == ARB_STREAM) && sel_valid && !uart_fifo_full_i;

    assign busy_o  = (state_q != ARB_IDLE);
    assign grant_o = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        uart_wr_en_o = 1'b0;
        uart_data_o  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_HEADER;
                end
            end
            ARB_HEADER: begin
                if (!uart_fifo_full_i) begin
                    uart_wr_en_o = 1'b1;
                    uart_data_o  = hdr_byte(HDR_TAG, 4'(grant_q));
                    state_d      = ARB_STREAM;
                end
            end
            ARB_STREAM: begin
                // Grant is held through valid gaps; only the last byte releases it.
                uart_data_o  = sel_data;
                uart_wr_en_o = sel_valid && !uart_fifo_full_i;
                if (xfer && sel_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
